// File: rtl/dadd_opnd_defs_pkg.sv
// rtl/dadd_opnd_defs_pkg.sv - shared constants and pair type for the dadd operand pairer
package dadd_opnd_defs_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int LVL_W_DEF  = $clog2(DEPTH_DEF) + 1;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] b;
    } pair_t;

endpackage

// File: rtl/dadd_opnd_fifo.sv
// rtl/dadd_opnd_fifo.sv - single-clock operand FIFO with flush, level and head-of-queue data
module dadd_opnd_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Storage is not reset: the level counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/dadd_opnd_pairer.sv
// rtl/dadd_opnd_pairer.sv - pairs buffered A and B operand streams into one stream for dadd
module dadd_opnd_pairer
    import dadd_opnd_defs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       a_vld,
    input  logic [DATA_W-1:0]          a_data,
    output logic                       a_rdy,
    input  logic                       b_vld,
    input  logic [DATA_W-1:0]          b_data,
    output logic                       b_rdy,
    output logic                       out_vld,
    output logic [DATA_W-1:0]          out_a,
    output logic [DATA_W-1:0]          out_b,
    input  logic                       out_rdy,
    output logic [CNT_W-1:0]           pair_cnt,
    output logic [$clog2(DEPTH):0]     a_lvl,
    output logic [$clog2(DEPTH):0]     b_lvl
);

    logic              a_full;
    logic              b_full;
    logic              a_empty;
    logic              b_empty;
    logic [DATA_W-1:0] a_head;
    logic [DATA_W-1:0] b_head;
    logic              a_push;
    logic              b_push;
    logic              pair_pop;

    // Ready deliberately ignores a same-cycle pop, keeping a_rdy off the out_rdy path.
    assign a_rdy  = rst_n && !flush && !a_full;
    assign b_rdy  = rst_n && !flush && !b_full;
    assign a_push = a_vld && a_rdy;
    assign b_push = b_vld && b_rdy;

    assign out_vld  = !a_empty && !b_empty;
    assign pair_pop = out_vld && out_rdy && !flush;
    assign out_a    = out_vld ? a_head : '0;
    assign out_b    = out_vld ? b_head : '0;

    dadd_opnd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (a_push),
        .pop   (pair_pop),
        .wdata (a_data),
        .level (a_lvl),
        .full  (a_full),
        .empty (a_empty),
        .head  (a_head)
    );

    dadd_opnd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (b_push),
        .pop   (pair_pop),
        .wdata (b_data),
        .level (b_lvl),
        .full  (b_full),
        .empty (b_empty),
        .head  (b_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt <= '0;
        end else if (flush) begin
            pair_cnt <= '0;
        end else if (pair_pop && (pair_cnt != '1)) begin
            pair_cnt <= pair_cnt + 1'b1;
        end
    end

endmodule

// File: doc/dadd_opnd_pairer.md
Name: dadd_opnd_pairer

Overview:
- Upstream feeder stage for the dadd adder DUT.
- Accepts two independent operand streams (A and B), each with valid/ready handshake, and buffers each in a small FIFO.
- Pairs the oldest A with the oldest B and presents the pair to dadd over a single valid/ready interface.
- Also provides a pair counter and fill-level status for the testbench and debug.

Parameters:
- DATA_W, 8, operand width in bits (same as dadd operand width).
- DEPTH, 4, entries per operand FIFO; must be a power of 2 and >= 2.
- CNT_W, 16, width of the issued-pair counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of both FIFOs and the counter.
- a_vld  in  1  operand A valid.
- a_data  in  DATA_W  operand A.
- a_rdy  out  1  operand A ready.
- b_vld  in  1  operand B valid.
- b_data  in  DATA_W  operand B.
- b_rdy  out  1  operand B ready.
- out_vld  out  1  pair valid towards dadd.
- out_a  out  DATA_W  paired operand A.
- out_b  out  DATA_W  paired operand B.
- out_rdy  in  1  dadd accepts pair.
- pair_cnt  out  CNT_W  number of pairs transferred.
- a_lvl  out  $clog2(DEPTH)+1  A FIFO occupancy.
- b_lvl  out  $clog2(DEPTH)+1  B FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, levels and pair_cnt go to 0.
  - out_vld=0 and out_a/out_b=0 (gated while empty).
  - a_rdy/b_rdy are forced 0 while rst_n is low.
  - First push is allowed on the first rising edge after rst_n goes high.
- Push:
  - A entry is written when a_vld && a_rdy; same rule for B.
  - a_rdy = rst_n && !flush && (a_lvl != DEPTH). No bypass: a full FIFO stays not-ready even if a pop occurs in the same cycle.
- Pair valid:
  - out_vld = (a_lvl != 0) && (b_lvl != 0).
  - out_a/out_b = FIFO head entries, driven combinationally from storage at the read pointers; forced to 0 when out_vld=0.
- Latency: 1 cycle minimum. An operand pushed at edge N is visible at out_* after edge N, provided the other FIFO is non-empty.
- Pop: both FIFOs pop together on out_vld && out_rdy. They never pop individually.
- Hold rule: while out_vld=1 and out_rdy=0, out_a/out_b hold stable.
- Simultaneous push and pop on one FIFO: level unchanged; write and read pointers both advance.
- Pointers: wrap modulo DEPTH using $clog2(DEPTH)-bit pointers. Level is tracked in a separate counter with range 0..DEPTH.
- pair_cnt: increments by 1 on each pair transfer; saturates at 2^CNT_W-1 and does not wrap.
- Flush (synchronous, highest priority):
  - In a flush cycle, pushes and pops are ignored.
  - Levels, pointers and pair_cnt clear to 0 on that edge.
  - out_vld may be 1 during the flush cycle itself, but any handshake in that cycle is ignored by this block; dadd must not sample a pair while flush=1.
- Unpaired surplus: if one stream runs ahead, its FIFO fills and backpressures; the other stream is unaffected.
- Reset mid-operation: all in-flight entries are discarded immediately (asynchronous); no partial pair is emitted.

Decomposition:
- Shared package dadd_opnd_defs_pkg holds:
  - DATA_W and DEPTH default constants.
  - The pair struct typedef (a, b).
  - A localparam for level width.
- One natural sub-module: dadd_opnd_fifo. It is a single-clock synchronous FIFO with push/pop/flush, level output and head data, and is instantiated twice (A and B).
- Pairing logic and pair_cnt live in the top.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with a_vld=b_vld=1 -> a_rdy=b_rdy=0, out_vld=0, pair_cnt=0, a_lvl=b_lvl=0. After release, a_rdy=b_rdy=1.
- Basic pairing: push A=0x12 and B=0x34 on the same edge, out_rdy=1 -> next cycle out_vld=1, out_a=0x12, out_b=0x34. After the accept edge, pair_cnt=1 and levels=0.
- Skew/backpressure: push A=1,2,3,4,5 with b_vld=0 -> a_lvl=4 and a_rdy=0 after the 4th push. Value 5 is held at the source. Then push B=9 -> pair (1,9) is emitted.
- Stall: 2 pairs queued with out_rdy=0 for 5 cycles -> out_vld=1 and out_a/out_b stable on the first pair. pair_cnt increments only on the cycles where out_rdy=1.
- Full with simultaneous pop: A FIFO full, B non-empty, out_rdy=1 -> a_lvl drops to 3. a_rdy=0 in the pop cycle and 1 in the next cycle. Pointer wrap is checked over 10 consecutive pairs with the data order preserved.
- Flush / counter saturation:
  - Flush with a_lvl=3, b_lvl=1 -> next cycle levels=0, out_vld=0, pair_cnt=0.
  - With CNT_W=2, run 5 pairs -> pair_cnt=3.
